// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute hazard inputs plus the stage
// enables, flushes and performance counters the controller drives back.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             ex_mem_read, branch_taken, jump, mc_start, cnt_clr;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs, id_rt, ex_rt, ex_mem_read, branch_taken, jump, mc_start, cnt_clr,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, ex_mem_read, branch_taken, jump, mc_start, cnt_clr,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end sequencing: freezes for multi-cycle EX ops, stalls on load-use,
// flushes IF/ID on ID-resolved redirects, and counts stall/flush cycles.
module pipeline_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_BUSY = 1'b1;
  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);
  localparam bit         MC_MULTI = (MC_LAT > 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state;
  logic [3:0]       mc_cnt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             freeze, lu, redir;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;

  // Reset masks every hazard term so the pipeline free-runs while held.
  assign freeze = !reset && (state == MC_BUSY || hz.mc_start);
  assign lu     = !reset && hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                  (hz.ex_rt == hz.id_rs || hz.ex_rt == hz.id_rt);
  assign redir  = !reset && (hz.branch_taken || hz.jump);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    if (freeze) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
    end else if (lu) begin
      // ID operands are stale, so any branch decision waits for the retry.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (redir) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      mc_cnt <= 4'd0;
    end else begin
      case (state)
        RUN: if (hz.mc_start && MC_MULTI) begin
          state  <= MC_BUSY;
          mc_cnt <= MC_INIT;
        end
        MC_BUSY: if (mc_cnt == 4'd1) begin
          state  <= RUN;
          mc_cnt <= 4'd0;
        end else begin
          mc_cnt <= mc_cnt - 4'd1;
        end
        default: begin
          state  <= RUN;
          mc_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.if_id_en    = if_id_en;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_en    = id_ex_en;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.busy        = freeze;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Two controllers (MC_LAT=4/CNT_W=16 and MC_LAT=2/CNT_W=4) on shared stimulus,
// checked by directed scenarios and a random run against a cycle-count model.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       ex_mem_read = 0, branch_taken = 0, jump = 0, mc_start = 0, cnt_clr = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) ifa ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  ifb ();

  assign ifa.id_rs = id_rs;  assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;  assign ifb.id_rt = id_rt;
  assign ifa.ex_rt = ex_rt;  assign ifb.ex_rt = ex_rt;
  assign ifa.ex_mem_read  = ex_mem_read;  assign ifb.ex_mem_read  = ex_mem_read;
  assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;
  assign ifa.jump     = jump;     assign ifb.jump     = jump;
  assign ifa.mc_start = mc_start; assign ifb.mc_start = mc_start;
  assign ifa.cnt_clr  = cnt_clr;  assign ifb.cnt_clr  = cnt_clr;

  pipeline_hazard_ctrl #(.MC_LAT(4), .CNT_W(16)) dut_a (.clk(clk), .reset(rst), .hz(ifa));
  pipeline_hazard_ctrl #(.MC_LAT(2), .CNT_W(4))  dut_b (.clk(clk), .reset(rst), .hz(ifb));

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, busy}
  logic [5:0]  oa, ob;
  logic [15:0] sa, fa, sb, fb;
  assign oa = {ifa.pc_en, ifa.if_id_en, ifa.if_id_flush, ifa.id_ex_en, ifa.id_ex_flush, ifa.busy};
  assign ob = {ifb.pc_en, ifb.if_id_en, ifb.if_id_flush, ifb.id_ex_en, ifb.id_ex_flush, ifb.busy};
  assign sa = ifa.stall_cnt;
  assign fa = ifa.flush_cnt;
  assign sb = {12'd0, ifb.stall_cnt};
  assign fb = {12'd0, ifb.flush_cnt};

  // Model: freeze cycles still owed after the current one, plus counters.
  int lat[2]  = '{4, 2};
  int cmax[2] = '{65535, 15};
  int fl[2], sc[2], fc[2];

  function automatic logic [5:0] mexp(int k);
    bit hit;
    hit = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    if (rst)                        return 6'b110100;
    if (fl[k] > 0 || mc_start)      return 6'b000001;
    if (hit)                        return 6'b000110;
    if (branch_taken || jump)       return 6'b111100;
    return 6'b110100;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin fl[k] = 0; sc[k] = 0; fc[k] = 0; end
  endtask

  task automatic adv();
    int nfl[2], nsc[2], nfc[2];
    logic [5:0] e;
    for (int k = 0; k < 2; k++) begin
      e = mexp(k);
      nfl[k] = (fl[k] > 0) ? fl[k] - 1 : ((mc_start && !rst) ? lat[k] - 2 : 0);
      nsc[k] = sc[k]; nfc[k] = fc[k];
      if (rst || cnt_clr) begin nsc[k] = 0; nfc[k] = 0; end
      else begin
        if (!e[5] && sc[k] < cmax[k]) nsc[k] = sc[k] + 1;
        if (e[3] && fc[k] < cmax[k])  nfc[k] = fc[k] + 1;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin fl[k] = nfl[k]; sc[k] = nsc[k]; fc[k] = nfc[k]; end
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; ex_mem_read = 0;
    branch_taken = 0; jump = 0; mc_start = 0; cnt_clr = 0;
  endtask

  task automatic clear_counters();
    idle(); cnt_clr = 1; adv(); cnt_clr = 0;
  endtask

  task automatic test_reset();
    // Hazards and mc_start present while reset is held must not show through.
    mc_start = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3; jump = 1;
    #1;
    checks++;
    if (oa !== 6'b110100 || ob !== 6'b110100) begin
      failures++; $display("FAIL reset_hold outs a=%b b=%b want 110100", oa, ob);
    end
    idle(); model_reset();
    @(negedge clk); rst = 0; #1;
    checks++;
    if (oa !== 6'b110100 || sa !== 0 || fa !== 0 || sb !== 0 || fb !== 0) begin
      failures++; $display("FAIL reset_release outs=%b st=%0d fl=%0d want 110100/0/0", oa, sa, fa);
    end
    adv();
  endtask

  task automatic test_load_use();
    clear_counters();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; #1;
    checks++;
    if (oa !== 6'b000110) begin failures++; $display("FAIL lu_rs outs=%b want 000110", oa); end
    adv(); idle(); #1;
    checks++;
    if (sa !== 1 || oa !== 6'b110100) begin
      failures++; $display("FAIL lu_count stall=%0d outs=%b want 1/110100", sa, oa);
    end
    ex_mem_read = 1; ex_rt = 7; id_rt = 7; #1;
    checks++;
    if (oa[5] !== 1'b0 || oa[1] !== 1'b1) begin failures++; $display("FAIL lu_rt outs=%b want 00xx1x", oa); end
    adv();
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_rt = 0; #1;
    checks++;
    if (oa !== 6'b110100) begin failures++; $display("FAIL lu_r0 outs=%b want 110100", oa); end
    adv(); idle(); #1;
    checks++;
    if (sa !== 2) begin failures++; $display("FAIL lu_r0_count stall=%0d want 2", sa); end
  endtask

  task automatic test_redirect();
    clear_counters();
    branch_taken = 1; #1;
    checks++;
    if (oa !== 6'b111100) begin failures++; $display("FAIL branch outs=%b want 111100", oa); end
    adv(); idle(); #1;
    checks++;
    if (fa !== 1 || sa !== 0) begin failures++; $display("FAIL branch_count fl=%0d st=%0d want 1/0", fa, sa); end
    branch_taken = 1; ex_mem_read = 1; ex_rt = 9; id_rs = 9; #1;
    checks++;
    if (oa !== 6'b000110) begin failures++; $display("FAIL branch_lu outs=%b want 000110", oa); end
    adv(); idle(); #1;
    checks++;
    if (fa !== 1 || sa !== 1) begin failures++; $display("FAIL branch_lu_count fl=%0d st=%0d want 1/1", fa, sa); end
  endtask

  task automatic test_mc_freeze();
    int sta, stb, bza, bzb;
    clear_counters();
    sta = 0; stb = 0; bza = 0; bzb = 0;
    mc_start = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (!oa[5]) sta++;
      if (!ob[5]) stb++;
      if (oa[0]) bza++;
      if (ob[0]) bzb++;
      adv(); mc_start = 0;
    end
    checks++;
    if (sta !== 3 || bza !== 3) begin failures++; $display("FAIL mc4_len stall=%0d busy=%0d want 3/3", sta, bza); end
    checks++;
    if (stb !== 1 || bzb !== 1) begin failures++; $display("FAIL mc2_len stall=%0d busy=%0d want 1/1", stb, bzb); end
    checks++;
    if (sa !== 3 || sb !== 1) begin failures++; $display("FAIL mc_count a=%0d b=%0d want 3/1", sa, sb); end
  endtask

  task automatic test_jump_during_freeze();
    logic [5:0] ga[4], gb[4];
    idle(); mc_start = 1; jump = 1;
    for (int i = 0; i < 4; i++) begin
      #1; ga[i] = oa; gb[i] = ob;
      adv(); mc_start = 0;
    end
    jump = 0;
    checks++;
    if (ga[0] !== 6'b000001 || ga[1] !== 6'b000001 || ga[2] !== 6'b000001 || ga[3] !== 6'b111100) begin
      failures++; $display("FAIL jump_mc4 %b %b %b %b want 000001x3 then 111100", ga[0], ga[1], ga[2], ga[3]);
    end
    checks++;
    if (gb[0] !== 6'b000001 || gb[1] !== 6'b111100) begin
      failures++; $display("FAIL jump_mc2 %b %b want 000001 111100", gb[0], gb[1]);
    end
    adv();
  endtask

  task automatic test_async_reset();
    idle(); ex_mem_read = 1; ex_rt = 4; id_rs = 4; adv(); idle();
    mc_start = 1; adv(); mc_start = 0; #1;
    checks++;
    if (oa[0] !== 1'b1) begin failures++; $display("FAIL busy_before_rst busy=%b want 1", oa[0]); end
    #1 rst = 1; #1;
    checks++;
    if (oa !== 6'b110100 || sa !== 0 || fa !== 0) begin
      failures++; $display("FAIL async_rst outs=%b st=%0d fl=%0d want 110100/0/0", oa, sa, fa);
    end
    #1 rst = 0; model_reset(); #1;
    checks++;
    if (oa !== 6'b110100) begin failures++; $display("FAIL post_rst_run outs=%b want 110100", oa); end
    adv(); #1;
    checks++;
    if (oa !== 6'b110100 || sa !== 0) begin failures++; $display("FAIL post_rst_next outs=%b st=%0d want 110100/0", oa, sa); end
  endtask

  task automatic test_saturate_clear();
    clear_counters();
    ex_mem_read = 1; ex_rt = 6; id_rs = 6;
    for (int i = 0; i < 20; i++) adv();
    #1;
    checks++;
    if (sb !== 15 || sa !== 20) begin failures++; $display("FAIL saturate b=%0d a=%0d want 15/20", sb, sa); end
    cnt_clr = 1; adv(); cnt_clr = 0; idle(); #1;
    checks++;
    if (sb !== 0 || sa !== 0) begin failures++; $display("FAIL clear b=%0d a=%0d want 0/0", sb, sa); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      jump         = ($urandom_range(0, 6) == 0);
      mc_start     = ($urandom_range(0, 9) == 0);
      cnt_clr      = ($urandom_range(0, 40) == 0);
      #1;
      checks++;
      if (oa !== mexp(0) || ob !== mexp(1)) begin
        failures++; $display("FAIL rand_outs n=%0d a=%b/%b b=%b/%b", n, oa, mexp(0), ob, mexp(1));
      end
      checks++;
      if (sa !== 16'(sc[0]) || fa !== 16'(fc[0]) || sb !== 16'(sc[1]) || fb !== 16'(fc[1])) begin
        failures++; $display("FAIL rand_cnt n=%0d a=%0d/%0d want %0d/%0d b=%0d/%0d want %0d/%0d",
                             n, sa, fa, sc[0], fc[0], sb, fb, sc[1], fc[1]);
      end
      adv();
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_redirect();
    test_mc_freeze();
    test_jump_during_freeze();
    test_async_reset();
    test_saturate_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
